// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl_if
//  Purpose  : Bundle of every signal around alu_issue_ctrl: the command
//             handshake from the issue stage, the operand/select/result
//             path to the combinational ALU, the response handshake and
//             the error counter.
//  Modports :
//    slave  - the issue controller: consumes commands and ALU results,
//             drives ALU operands/select, responses and err_cnt.
//    master - the surrounding environment: issue stage, ALU and response
//             consumer.
//  Params   : WIDTH (operand/result width), TAG_W (command tag width).
//  Revision : 1.0  initial release
// ============================================================================
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    // Command channel
    logic             cmd_valid;
    logic             cmd_ready;
    logic [5:0]       cmd_funct;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [TAG_W-1:0] cmd_tag;

    // ALU path
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;

    // Response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;

    // Status
    logic [7:0]       err_cnt;

    modport slave (
        input  cmd_valid, cmd_funct, cmd_a, cmd_b, cmd_tag,
        output cmd_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_res, alu_zero,
        output rsp_valid, rsp_data, rsp_zero, rsp_err, rsp_tag,
        input  rsp_ready,
        output err_cnt
    );

    modport master (
        output cmd_valid, cmd_funct, cmd_a, cmd_b, cmd_tag,
        input  cmd_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_res, alu_zero,
        input  rsp_valid, rsp_data, rsp_zero, rsp_err, rsp_tag,
        output rsp_ready,
        input  err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl
//  Purpose  : Initiator-side front end for the 32-bit combinational ALU.
//             Accepts R-type commands over valid/ready, decodes funct into
//             the ALU select, drives registered operands into the ALU and
//             captures res/zero into a response register. Illegal funct
//             codes (and optionally divide-by-zero) are answered with an
//             error response and never reach the ALU.
//  Ports    :
//    clk            - single clock, rising edge
//    rst            - synchronous active-high reset
//    bus (slave)    - cmd_* handshake in, alu_a/alu_b/alu_sel out,
//                     alu_res/alu_zero in, rsp_* handshake out, err_cnt out
//  Params   : WIDTH (must match the ALU and the interface), TAG_W
//  Config   : ALU_ISSUE_DIVZERO_CHECK_EN - when defined, funct 0x1A with
//             cmd_b == 0 is rejected as an error instead of being issued.
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_ctrl_if.slave  bus
);

    // ------------------------------------------------------------------
    // Funct codes and ALU selects
    // ------------------------------------------------------------------
    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_MUL = 6'h18;
    localparam logic [5:0] c_FN_DIV = 6'h1A;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_XOR = 6'h26;
    localparam logic [5:0] c_FN_NOT = 6'h27;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    localparam logic [3:0] c_SEL_ADD = 4'b0000;
    localparam logic [3:0] c_SEL_SUB = 4'b0001;
    localparam logic [3:0] c_SEL_MUL = 4'b0010;
    localparam logic [3:0] c_SEL_DIV = 4'b0011;
    localparam logic [3:0] c_SEL_AND = 4'b0100;
    localparam logic [3:0] c_SEL_OR  = 4'b0101;
    localparam logic [3:0] c_SEL_XOR = 4'b0110;
    localparam logic [3:0] c_SEL_NOT = 4'b0111;
    localparam logic [3:0] c_SEL_SLT = 4'b1000;

    localparam logic [7:0] c_ERR_MAX = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic             r_cmd_ready;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_alu_sel;
    logic [TAG_W-1:0] r_tag;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_zero;
    logic             r_rsp_err;
    logic [TAG_W-1:0] r_rsp_tag;
    logic [7:0]       r_err_cnt;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [3:0] w_sel;
    logic       w_legal;
    logic       w_divzero;
    logic       w_reject;

    always_comb begin
        w_sel   = c_SEL_ADD;
        w_legal = 1'b1;
        case (bus.cmd_funct)
            c_FN_ADD: w_sel = c_SEL_ADD;
            c_FN_SUB: w_sel = c_SEL_SUB;
            c_FN_MUL: w_sel = c_SEL_MUL;
            c_FN_DIV: w_sel = c_SEL_DIV;
            c_FN_AND: w_sel = c_SEL_AND;
            c_FN_OR:  w_sel = c_SEL_OR;
            c_FN_XOR: w_sel = c_SEL_XOR;
            c_FN_NOT: w_sel = c_SEL_NOT;
            c_FN_SLT: w_sel = c_SEL_SLT;
            default:  w_legal = 1'b0;
        endcase
    end

`ifdef ALU_ISSUE_DIVZERO_CHECK_EN
    assign w_divzero = (bus.cmd_funct == c_FN_DIV) && (bus.cmd_b == '0);
`else
    assign w_divzero = 1'b0;
`endif

    assign w_reject = !w_legal || w_divzero;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // cmd_ready/rsp_valid are kept as flops that track the next state so
    // the handshake outputs come straight from registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= c_SEL_ADD;
            r_tag       <= '0;
            r_rsp_data  <= '0;
            r_rsp_zero  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_tag   <= '0;
            r_err_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        if (w_reject) begin
                            // Rejected commands answer immediately and
                            // leave the ALU operand registers untouched.
                            r_rsp_data  <= '0;
                            r_rsp_zero  <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_tag   <= bus.cmd_tag;
                            r_rsp_valid <= 1'b1;
                            if (r_err_cnt != c_ERR_MAX) begin
                                r_err_cnt <= r_err_cnt + 8'd1;
                            end
                            r_state <= S_RESP;
                        end else begin
                            r_alu_a   <= bus.cmd_a;
                            r_alu_b   <= bus.cmd_b;
                            r_alu_sel <= w_sel;
                            r_tag     <= bus.cmd_tag;
                            r_state   <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    // The ALU has had a full cycle to settle on the
                    // registered operands.
                    r_rsp_data  <= bus.alu_res;
                    r_rsp_zero  <= bus.alu_zero;
                    r_rsp_err   <= 1'b0;
                    r_rsp_tag   <= r_tag;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end

                S_RESP: begin
                    // Ready only returns after the consume edge, so a new
                    // command cannot be taken in the same cycle.
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.cmd_ready = r_cmd_ready;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_sel   = r_alu_sel;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_zero  = r_rsp_zero;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_tag   = r_rsp_tag;
    assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_ctrl
//  Purpose  : Directed self-checking bench for alu_issue_ctrl with a small
//             behavioural ALU attached to the operand/select outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;
    int n_err;
    logic [3:0] last_sel;

    alu_issue_ctrl_if #(.WIDTH(32), .TAG_W(4)) bus ();

    alu_issue_ctrl #(.WIDTH(32), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; division by zero returns all ones.
    always_comb begin
        case (bus.alu_sel)
            4'd0: bus.alu_res = bus.alu_a + bus.alu_b;
            4'd1: bus.alu_res = bus.alu_a - bus.alu_b;
            4'd2: bus.alu_res = bus.alu_a * bus.alu_b;
            4'd3: bus.alu_res = (bus.alu_b == 32'd0) ? 32'hFFFF_FFFF : bus.alu_a / bus.alu_b;
            4'd4: bus.alu_res = bus.alu_a & bus.alu_b;
            4'd5: bus.alu_res = bus.alu_a | bus.alu_b;
            4'd6: bus.alu_res = bus.alu_a ^ bus.alu_b;
            4'd7: bus.alu_res = ~bus.alu_a;
            4'd8: bus.alu_res = (bus.alu_a < bus.alu_b) ? 32'd1 : 32'd0;
            default: bus.alu_res = 32'd0;
        endcase
        bus.alu_zero = (bus.alu_res == 32'd0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one command at a negedge and hold it through one rising edge.
    task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("cmd_ready_timeout", 64'd0, 64'd1);
        bus.cmd_funct = f;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_tag   = t;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Send a command with rsp_ready high and check latency and response.
    task automatic run_cmd(input string nm, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] t, input bit exp_err,
                           input logic [31:0] exp_data, input logic [3:0] exp_sel);
        send(f, a, b, t);
        @(negedge clk);
        if (!exp_err) begin
            check({nm, "_issue_valid"}, 64'(bus.rsp_valid), 64'd0);
            check({nm, "_sel"},         64'(bus.alu_sel),   64'(exp_sel));
            check({nm, "_alu_a"},       64'(bus.alu_a),     64'(a));
            last_sel = exp_sel;
            @(negedge clk);
        end else begin
            n_err++;
            check({nm, "_sel_hold"}, 64'(bus.alu_sel), 64'(last_sel));
        end
        check({nm, "_valid"}, 64'(bus.rsp_valid), 64'd1);
        check({nm, "_data"},  64'(bus.rsp_data),  64'(exp_data));
        check({nm, "_zero"},  64'(bus.rsp_zero),  64'(exp_err || exp_data == 32'd0));
        check({nm, "_err"},   64'(bus.rsp_err),   64'(exp_err));
        check({nm, "_tag"},   64'(bus.rsp_tag),   64'(t));
        check({nm, "_errcnt"}, 64'(bus.err_cnt),  64'((n_err > 255) ? 255 : n_err));
    endtask

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [31:0] d;
    } vec_t;

    vec_t vecs[11];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_err    = 0;
        last_sel = 4'd0;
        bus.cmd_valid = 1'b0;
        bus.cmd_funct = 6'h0;
        bus.cmd_a     = 32'd0;
        bus.cmd_b     = 32'd0;
        bus.cmd_tag   = 4'd0;
        bus.rsp_ready = 1'b1;

        vecs[0]  = '{6'h20, 32'd5,         32'd7,         4'd0, 32'd12};
        vecs[1]  = '{6'h22, 32'h1234,      32'h1234,      4'd1, 32'd0};
        vecs[2]  = '{6'h18, 32'd6,         32'd7,         4'd2, 32'd42};
        vecs[3]  = '{6'h1A, 32'd100,       32'd7,         4'd3, 32'd14};
        vecs[4]  = '{6'h24, 32'hF0F0,      32'hFF00,      4'd4, 32'hF000};
        vecs[5]  = '{6'h25, 32'hF0F0,      32'h0F0F,      4'd5, 32'hFFFF};
        vecs[6]  = '{6'h26, 32'hFF00_FF00, 32'hFFFF_0000, 4'd6, 32'h00FF_FF00};
        vecs[7]  = '{6'h27, 32'd0,         32'd3,         4'd7, 32'hFFFF_FFFF};
        vecs[8]  = '{6'h2A, 32'd2,         32'd9,         4'd8, 32'd1};
        vecs[9]  = '{6'h2A, 32'd9,         32'd2,         4'd8, 32'd0};
        vecs[10] = '{6'h2A, 32'd1,         32'hFFFF_FFFF, 4'd8, 32'd1};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_err_cnt",   64'(bus.err_cnt),   64'd0);
        check("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
        check("rst_rsp_misc",  64'({bus.rsp_zero, bus.rsp_err, bus.rsp_tag}), 64'd0);
        check("rst_alu",       64'({bus.alu_sel, bus.alu_a}), 64'd0);
        check("rst_alu_b",     64'(bus.alu_b), 64'd0);

        // Add with a stalled consumer; a command offered during the stall
        // must be ignored.
        bus.rsp_ready = 1'b0;
        send(6'h20, 32'd5, 32'd7, 4'd3);
        @(negedge clk);
        check("stall_sel",       64'(bus.alu_sel),   64'd0);
        check("stall_alu_b",     64'(bus.alu_b),     64'd7);
        check("stall_issue_vld", 64'(bus.rsp_valid), 64'd0);
        check("stall_issue_rdy", 64'(bus.cmd_ready), 64'd0);
        @(negedge clk);
        check("stall_valid", 64'(bus.rsp_valid), 64'd1);
        check("stall_data",  64'(bus.rsp_data),  64'd12);
        check("stall_zero",  64'(bus.rsp_zero),  64'd0);
        check("stall_tag",   64'(bus.rsp_tag),   64'd3);
        bus.cmd_funct = 6'h3F;
        bus.cmd_tag   = 4'd9;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_hold_valid", 64'(bus.rsp_valid), 64'd1);
            check("stall_hold_data",  64'(bus.rsp_data),  64'd12);
            check("stall_hold_tag",   64'(bus.rsp_tag),   64'd3);
            check("stall_hold_rdy",   64'(bus.cmd_ready), 64'd0);
            check("stall_hold_err",   64'(bus.err_cnt),   64'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("release_valid", 64'(bus.rsp_valid), 64'd0);
        check("release_ready", 64'(bus.cmd_ready), 64'd1);
        check("release_err",   64'(bus.err_cnt),   64'd0);

        // All legal functions
        for (int i = 0; i < 11; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                    4'(i), 1'b0, vecs[i].d, vecs[i].sel);
        end

        // Illegal funct
        run_cmd("illegal", 6'h3F, 32'd1, 32'd2, 4'd5, 1'b1, 32'd0, 4'd0);

        // Divide by zero
`ifdef ALU_ISSUE_DIVZERO_CHECK_EN
        run_cmd("divzero", 6'h1A, 32'd10, 32'd0, 4'd7, 1'b1, 32'd0, 4'd0);
`else
        run_cmd("divzero", 6'h1A, 32'd10, 32'd0, 4'd7, 1'b0, 32'hFFFF_FFFF, 4'd3);
`endif

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            send(6'h00, 32'd0, 32'd0, 4'd1);
            n_err++;
        end
        @(negedge clk);
        check("err_sat", 64'(bus.err_cnt), 64'd255);
        run_cmd("illegal_sat", 6'h01, 32'd0, 32'd0, 4'd2, 1'b1, 32'd0, 4'd0);

        // Reset during ISSUE drops the command
        send(6'h1A, 32'd10, 32'd2, 4'd6);
        @(negedge clk);
        check("pre_rst_sel", 64'(bus.alu_sel), 64'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("midrst_rsp_data",  64'(bus.rsp_data),  64'd0);
        check("midrst_rsp_misc",  64'({bus.rsp_zero, bus.rsp_err, bus.rsp_tag}), 64'd0);
        check("midrst_alu",       64'({bus.alu_sel, bus.alu_a}), 64'd0);
        check("midrst_alu_b",     64'(bus.alu_b), 64'd0);
        check("midrst_err_cnt",   64'(bus.err_cnt), 64'd0);
        n_err    = 0;
        last_sel = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        run_cmd("postrst_add", 6'h20, 32'd1, 32'd1, 4'd4, 1'b0, 32'd2, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Initiator-side front end for the 32-bit combinational ALU. Accepts R-type commands (funct code, two operands, tag) over a valid/ready handshake, decodes funct into the ALU's 4-bit `sel`, drives registered operands into the ALU, and captures `res`/`zero` into a response register. Sits between the datapath issue stage and the ALU; screens illegal funct codes and divide-by-zero so that no undefined operation reaches the ALU.

## Interface
- `WIDTH`, 32, operand/result width; must match the ALU.
- `TAG_W`, 4, command tag width; the tag is echoed unchanged on the response.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_funct` in 6: R-type funct code.
- `cmd_a`, `cmd_b` in WIDTH: operands.
- `cmd_tag` in TAG_W: command tag.
- `alu_a`, `alu_b` out WIDTH: registered operands to the ALU.
- `alu_sel` out 4: registered ALU select.
- `alu_res` in WIDTH: ALU result (combinational).
- `alu_zero` in 1: ALU zero flag.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out WIDTH: result.
- `rsp_zero` out 1: zero flag.
- `rsp_err` out 1: command was rejected.
- `rsp_tag` out TAG_W: echoed tag.
- `err_cnt` out 8: saturating count of rejected commands.

## Operation
- Decode of funct to `sel`:
  - 0x20 → 0000 (add)
  - 0x22 → 0001 (sub)
  - 0x18 → 0010 (mul)
  - 0x1A → 0011 (div)
  - 0x24 → 0100 (and)
  - 0x25 → 0101 (or)
  - 0x26 → 0110 (xor)
  - 0x27 → 0111 (not A)
  - 0x2A → 1000 (slt, unsigned)
  - Any other funct is illegal.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On handshake with a legal funct and no div-by-zero: load `alu_a`/`alu_b`/`alu_sel` and the tag register, then go to ISSUE.
  - On handshake with an illegal funct or div-by-zero: load `rsp_data`=0, `rsp_zero`=1, `rsp_err`=1, `rsp_tag`=`cmd_tag`; increment `err_cnt` (saturates at 255); go to RESP. ALU registers are unchanged.
- ISSUE:
  - `cmd_ready`=0.
  - Capture `rsp_data`=`alu_res`, `rsp_zero`=`alu_zero`, `rsp_err`=0, `rsp_tag`=tag; go to RESP.
- RESP:
  - `rsp_valid`=1 and `cmd_ready`=0.
  - All `rsp_*` outputs hold stable until `rsp_ready`=1; then go to IDLE.
  - A new command is not accepted in the same cycle the response is consumed.
- `alu_a`/`alu_b`/`alu_sel` hold their last issued values outside ISSUE.
- All widths are exact; the block does no arithmetic itself other than the `err_cnt` increment.

## Timing
- Reset values:
  - State = IDLE, `cmd_ready`=1, `rsp_valid`=0.
  - `rsp_data`=0, `rsp_zero`=0, `rsp_err`=0, `rsp_tag`=0.
  - `alu_a`=0, `alu_b`=0, `alu_sel`=0000, `err_cnt`=0.
- Legal command accepted at edge N:
  - `alu_*` are valid after edge N.
  - Result is captured at edge N+1.
  - `rsp_valid`=1 from edge N+1.
- Rejected command accepted at edge N: `rsp_valid`=1 from edge N.
- Throughput:
  - At most one legal command per 3 cycles with `rsp_ready` held high.
  - At most one rejected command per 2 cycles.
- `cmd_valid` while `cmd_ready`=0 has no effect; the initiator must hold the command.
- Reset asserted in any state returns to reset values at the next edge. An in-flight command is dropped with no response.
- The ALU path (`alu_*` registers → ALU → `rsp_data`) is one full cycle.

## Configuration
- `ALU_ISSUE_DIVZERO_CHECK_EN` defined:
  - funct 0x1A with `cmd_b`==0 is rejected as an error.
  - `err_cnt` increments.
  - Latency is that of a rejected command.
- Not defined:
  - Divide-by-zero is issued to the ALU like any legal command.
  - `rsp_data`/`rsp_zero` carry whatever the ALU returns.
  - `rsp_err`=0.
  - Only illegal funct codes are rejected.

## Test plan
- Reset then idle: `cmd_ready`=1, `rsp_valid`=0, `err_cnt`=0, all outputs 0.
- Add, stall then release:
  - Stimulus: funct 0x20, A=5, B=7, tag=3, `rsp_ready`=0 for 4 cycles, then 1.
  - Response: `alu_sel`=0000 one edge after accept; `rsp_valid` one edge later with `rsp_data`=12, `rsp_zero`=0, `rsp_tag`=3.
  - Response stays stable throughout the stall, then returns to IDLE.
- Sub to zero: funct 0x22, A=B=0x1234 → `rsp_data`=0, `rsp_zero`=1, `rsp_err`=0.
- slt: funct 0x2A, A=2, B=9 → `rsp_data`=1. Then A=9, B=2 → `rsp_data`=0, `rsp_zero`=1.
- Illegal funct 0x3F, tag=5:
  - `rsp_valid` one edge after accept with `rsp_err`=1, `rsp_data`=0, `rsp_tag`=5.
  - `err_cnt`=1; `alu_sel` unchanged.
  - After 300 illegal commands, `err_cnt`=255.
- Div A=10, B=0, then `rst` pulsed during ISSUE of a div A=10, B=2:
  - With the macro: the first command gives `rsp_err`=1.
  - The reset drops the second command: no response, all outputs return to reset values, `cmd_ready`=1 after the reset edge.
